img_streamer: RTL and testbench

IMG_STREAMER -- requirements
Module: img_streamer

---
 rtl/img_streamer_pkg.sv | 24 ++
 rtl/stream_skid_buf.sv | 47 ++++
 rtl/img_streamer.sv | 100 ++++++++++
 tb/tb_img_streamer.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_streamer_pkg.sv
// Shared definitions for the image-pipeline blocks: controller states,
// skid-buffer depth and a ceil-log2 helper for address widths.
package img_streamer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } stream_state_t;

    localparam int SKID_DEPTH = 3;

    // Never returns less than 1 so a 1x1 image still gets a real address port.
    function automatic int CLOG2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Three-entry in-order buffer between the pixel memory and the output FIFO.
// Accepts a push in the same cycle as a pop even when full.
module stream_skid_buf
    import img_streamer_pkg::*;
#(
    parameter int DWIDTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DWIDTH-1:0] din,
    output logic [DWIDTH-1:0] dout,
    output logic [1:0]        count
);

    localparam logic [1:0] LAST_SLOT  = 2'(SKID_DEPTH - 1);
    localparam logic [1:0] FULL_COUNT = 2'(SKID_DEPTH);

    logic [DWIDTH-1:0] slots [SKID_DEPTH];
    logic [1:0]        rd_ptr;
    logic [1:0]        wr_ptr;
    logic              do_push;
    logic              do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != FULL_COUNT) || do_pop);
    assign dout    = (count != 2'd0) ? slots[rd_ptr] : '0;

    always_ff @(posedge clock) begin
        if (do_push) slots[wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rd_ptr <= 2'd0;
            wr_ptr <= 2'd0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == LAST_SLOT) ? 2'd0 : wr_ptr + 2'd1;
            if (do_pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? 2'd0 : rd_ptr + 2'd1;
            if (do_push && !do_pop)      count <= count + 2'd1;
            else if (do_pop && !do_push) count <= count - 2'd1;
        end
    end

endmodule

// File: rtl/img_streamer.sv
// Streams one frame of pixels from a synchronous-read memory into an output
// FIFO in raster order, tolerating arbitrary FIFO back-pressure.
module img_streamer
    import img_streamer_pkg::*;
#(
    parameter  int DWIDTH     = 8,
    parameter  int IMG_WIDTH  = 720,
    parameter  int IMG_HEIGHT = 540,
    localparam int AW         = CLOG2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [15:0]       frame_count,
    output logic              mem_rd_en,
    output logic [AW-1:0]     mem_addr,
    input  logic [DWIDTH-1:0] mem_dout,
    output logic              fifo_out_wr_en,
    output logic [DWIDTH-1:0] fifo_out_din,
    input  logic              fifo_out_full
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(IMG_WIDTH * IMG_HEIGHT - 1);

    stream_state_t     state;
    stream_state_t     state_next;
    logic [AW-1:0]     addr_q;
    logic              inflight_q;
    logic [15:0]       frame_cnt_q;
    logic [1:0]        buf_count;
    logic [DWIDTH-1:0] buf_head;
    logic [2:0]        pending;
    logic              drain_empty;

    stream_skid_buf #(
        .DWIDTH (DWIDTH)
    ) u_skid (
        .clock  (clock),
        .reset  (reset),
        .push   (inflight_q),
        .pop    (fifo_out_wr_en),
        .din    (mem_dout),
        .dout   (buf_head),
        .count  (buf_count)
    );

    // Reads are throttled so buffered plus returning pixels never exceed three.
    assign pending        = {1'b0, buf_count} + {2'b00, inflight_q};
    assign fifo_out_wr_en = (buf_count != 2'd0) && !fifo_out_full;
    assign fifo_out_din   = buf_head;
    assign mem_addr       = addr_q;
    assign frame_count    = frame_cnt_q;

    // Leave DRAIN on the cycle that writes the final pixel so done follows it directly.
    assign drain_empty = !inflight_q &&
                         ((buf_count == 2'd0) || ((buf_count == 2'd1) && fifo_out_wr_en));

    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        mem_rd_en  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_STREAM;
            end
            ST_STREAM: begin
                mem_rd_en = (pending <= 3'd2);
                if (mem_rd_en && (addr_q == LAST_ADDR)) state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (drain_empty) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= ST_IDLE;
            addr_q      <= '0;
            inflight_q  <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            state      <= state_next;
            inflight_q <= mem_rd_en;
            if (mem_rd_en) addr_q <= (addr_q == LAST_ADDR) ? '0 : addr_q + AW'(1);
            if ((state == ST_IDLE) && start) addr_q <= '0;
            if (state == ST_DONE) frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_img_streamer.sv
// Self-checking bench: three streamer instances (2x2, 4x4, 8x8) fed from
// behavioural memories; output pixel streams are compared to memory contents.
module tb_img_streamer;

    logic clock = 1'b0;
    logic reset;
    logic start2, start4, start8;
    logic full2, full4, full8;
    logic busy2, busy4, busy8;
    logic done2, done4, done8;
    logic [15:0] fc2, fc4, fc8;
    logic rd2, rd4, rd8;
    logic [1:0] addr2;
    logic [3:0] addr4;
    logic [5:0] addr8;
    logic [7:0] dout2, dout4, dout8;
    logic wr2, wr4, wr8;
    logic [7:0] din2, din4, din8;

    logic [7:0] mem2 [4];
    logic [7:0] mem4 [16];
    logic [7:0] mem8 [64];

    int cyc = 0;
    int total = 0;
    int bad = 0;

    logic [7:0] got2[$], got4[$], got8[$];
    int wcyc2[$], wcyc4[$];
    int raddr2[$], raddr4[$], raddr8[$];
    int rcyc4[$];
    int done_cnt2 = 0, done_cnt4 = 0, done_cnt8 = 0;
    int done_cyc2 = 0;
    int viol4 = 0, viol8 = 0;

    img_streamer #(.DWIDTH(8), .IMG_WIDTH(2), .IMG_HEIGHT(2)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .busy(busy2), .done(done2),
        .frame_count(fc2), .mem_rd_en(rd2), .mem_addr(addr2), .mem_dout(dout2),
        .fifo_out_wr_en(wr2), .fifo_out_din(din2), .fifo_out_full(full2));

    img_streamer #(.DWIDTH(8), .IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
        .clock(clock), .reset(reset), .start(start4), .busy(busy4), .done(done4),
        .frame_count(fc4), .mem_rd_en(rd4), .mem_addr(addr4), .mem_dout(dout4),
        .fifo_out_wr_en(wr4), .fifo_out_din(din4), .fifo_out_full(full4));

    img_streamer #(.DWIDTH(8), .IMG_WIDTH(8), .IMG_HEIGHT(8)) dut8 (
        .clock(clock), .reset(reset), .start(start8), .busy(busy8), .done(done8),
        .frame_count(fc8), .mem_rd_en(rd8), .mem_addr(addr8), .mem_dout(dout8),
        .fifo_out_wr_en(wr8), .fifo_out_din(din8), .fifo_out_full(full8));

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous-read memories: data appears the cycle after the address.
    always @(posedge clock) begin
        dout2 <= mem2[addr2];
        dout4 <= mem4[addr4];
        dout8 <= mem8[addr8];
    end

    always @(negedge clock) begin
        if (wr2) begin got2.push_back(din2); wcyc2.push_back(cyc); end
        if (wr4) begin got4.push_back(din4); wcyc4.push_back(cyc); if (full4) viol4++; end
        if (wr8) begin got8.push_back(din8); if (full8) viol8++; end
        if (rd2) raddr2.push_back(int'(addr2));
        if (rd4) begin raddr4.push_back(int'(addr4)); rcyc4.push_back(cyc); end
        if (rd8) raddr8.push_back(int'(addr8));
        if (done2) begin done_cnt2++; done_cyc2 = cyc; end
        if (done4) done_cnt4++;
        if (done8) done_cnt8++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_done(input int sel, input int d0, input int limit, output bit ok);
        int cur;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            cur = (sel == 2) ? done_cnt2 : (sel == 4) ? done_cnt4 : done_cnt8;
            if (cur > d0) begin ok = 1'b1; break; end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) tick();
        total += 9;
        if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy4); end
        if (done4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_done: got %b expected 0", done4); end
        if (fc4 !== 16'd0) begin bad++; $display("[TB] FAIL reset_fc: got %0h expected 0", fc4); end
        if (rd4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_rd: got %b expected 0", rd4); end
        if (addr4 !== 4'd0) begin bad++; $display("[TB] FAIL reset_addr: got %0h expected 0", addr4); end
        if (wr4 !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr: got %b expected 0", wr4); end
        if (din4 !== 8'd0) begin bad++; $display("[TB] FAIL reset_din: got %0h expected 0", din4); end
        if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy2: got %b expected 0", busy2); end
        if (fc2 !== 16'd0) begin bad++; $display("[TB] FAIL reset_fc2: got %0h expected 0", fc2); end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_basic_2x2();
        int s, d0;
        got2.delete(); wcyc2.delete();
        d0 = done_cnt2;
        s = cyc;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        total += 2;
        if (rd2 !== 1'b1) begin bad++; $display("[TB] FAIL basic_first_rd: got %b expected 1", rd2); end
        if (addr2 !== 2'd0) begin bad++; $display("[TB] FAIL basic_first_addr: got %0d expected 0", addr2); end
        repeat (10) tick();
        total++;
        if (got2.size() != 4) begin bad++; $display("[TB] FAIL basic_count: got %0d expected 4", got2.size()); end
        for (int k = 0; k < 4 && k < got2.size(); k++) begin
            total += 2;
            if (got2[k] !== mem2[k]) begin bad++; $display("[TB] FAIL basic_pix%0d: got %0h expected %0h", k, got2[k], mem2[k]); end
            if (wcyc2[k] != s + 3 + k) begin bad++; $display("[TB] FAIL basic_wcyc%0d: got %0d expected %0d", k, wcyc2[k] - s, 3 + k); end
        end
        total += 4;
        if (done_cnt2 - d0 != 1) begin bad++; $display("[TB] FAIL basic_dones: got %0d expected 1", done_cnt2 - d0); end
        if (done_cyc2 != s + 7) begin bad++; $display("[TB] FAIL basic_done_cyc: got %0d expected 7", done_cyc2 - s); end
        if (fc2 !== 16'd1) begin bad++; $display("[TB] FAIL basic_fc: got %0d expected 1", fc2); end
        if (busy2 !== 1'b0) begin bad++; $display("[TB] FAIL basic_idle: got %b expected 0", busy2); end
    endtask

    task automatic test_frame_wrap();
        bit ok;
        logic [15:0] exp_fc;
        force dut2.frame_cnt_q = 16'hFFFE;
        tick();
        release dut2.frame_cnt_q;
        exp_fc = 16'hFFFE;
        for (int f = 0; f < 2; f++) begin
            raddr2.delete(); got2.delete();
            start2 = 1'b1;
            tick();
            start2 = 1'b0;
            wait_done(2, done_cnt2, 50, ok);
            exp_fc = exp_fc + 16'd1;
            total += 4;
            if (!ok) begin bad++; $display("[TB] FAIL wrap_timeout%0d: got none expected done", f); end
            if (fc2 !== exp_fc) begin bad++; $display("[TB] FAIL wrap_fc%0d: got %0h expected %0h", f, fc2, exp_fc); end
            if (raddr2.size() != 4 || raddr2[0] != 0) begin bad++; $display("[TB] FAIL wrap_addr%0d: got %0d reads expected 4 from 0", f, raddr2.size()); end
            if (got2.size() != 4) begin bad++; $display("[TB] FAIL wrap_pix%0d: got %0d expected 4", f, got2.size()); end
        end
    endtask

    task automatic test_backpressure();
        int s, d0, early;
        bit ok;
        for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
        got4.delete(); rcyc4.delete(); viol4 = 0;
        d0 = done_cnt4;
        s = cyc;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            full4 = ((cyc - s) >= 4) && ((cyc - s) <= 20);
            if (done_cnt4 > d0) begin ok = 1'b1; break; end
            tick();
        end
        full4 = 1'b0;
        early = 0;
        foreach (rcyc4[i]) if (rcyc4[i] <= s + 20) early++;
        total += 4;
        if (!ok) begin bad++; $display("[TB] FAIL bp_timeout: got none expected done"); end
        if (early != 4) begin bad++; $display("[TB] FAIL bp_reads_held: got %0d expected 4", early); end
        if (viol4 != 0) begin bad++; $display("[TB] FAIL bp_write_full: got %0d expected 0", viol4); end
        if (got4.size() != 16) begin bad++; $display("[TB] FAIL bp_count: got %0d expected 16", got4.size()); end
        for (int k = 0; k < 16 && k < got4.size(); k++) begin
            total++;
            if (got4[k] !== mem4[k]) begin bad++; $display("[TB] FAIL bp_pix%0d: got %0h expected %0h", k, got4[k], mem4[k]); end
        end
    endtask

    task automatic test_start_ignored();
        int s, d0;
        bit ok;
        for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
        got4.delete(); raddr4.delete();
        d0 = done_cnt4;
        s = cyc;
        start4 = 1'b1;
        tick();
        for (int i = 0; i < 100; i++) begin
            start4 = ((cyc - s) >= 2) && ((cyc - s) <= 15) && ($urandom_range(0, 3) != 0);
            if (done_cnt4 > d0) break;
            tick();
        end
        start4 = 1'b0;
        wait_done(4, d0, 10, ok);
        repeat (20) tick();
        total += 5;
        if (!ok) begin bad++; $display("[TB] FAIL ign_timeout: got none expected done"); end
        if (done_cnt4 - d0 != 1) begin bad++; $display("[TB] FAIL ign_dones: got %0d expected 1", done_cnt4 - d0); end
        if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL ign_idle: got %b expected 0", busy4); end
        if (raddr4.size() != 16) begin bad++; $display("[TB] FAIL ign_reads: got %0d expected 16", raddr4.size()); end
        if (got4.size() != 16) begin bad++; $display("[TB] FAIL ign_count: got %0d expected 16", got4.size()); end
        for (int k = 0; k < 16 && k < got4.size(); k++) begin
            total++;
            if (got4[k] !== mem4[k]) begin bad++; $display("[TB] FAIL ign_pix%0d: got %0h expected %0h", k, got4[k], mem4[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int s, d0, late;
        bit ok;
        for (int i = 0; i < 16; i++) mem4[i] = 8'($urandom);
        got4.delete(); wcyc4.delete();
        d0 = done_cnt4;
        s = cyc;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        while (cyc < s + 10) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        total += 3;
        if (busy4 !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b expected 0", busy4); end
        if (addr4 !== 4'd0) begin bad++; $display("[TB] FAIL rst_addr: got %0d expected 0", addr4); end
        if (wr4 !== 1'b0) begin bad++; $display("[TB] FAIL rst_wr: got %b expected 0", wr4); end
        repeat (30) tick();
        late = 0;
        foreach (wcyc4[i]) if (wcyc4[i] >= s + 11) late++;
        total += 3;
        if (late != 0) begin bad++; $display("[TB] FAIL rst_late_writes: got %0d expected 0", late); end
        if (fc4 !== 16'd0) begin bad++; $display("[TB] FAIL rst_fc: got %0d expected 0", fc4); end
        if (done_cnt4 != d0) begin bad++; $display("[TB] FAIL rst_done: got %0d expected 0", done_cnt4 - d0); end
        got4.delete(); raddr4.delete();
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        wait_done(4, d0, 100, ok);
        total += 3;
        if (!ok) begin bad++; $display("[TB] FAIL rst_restart_timeout: got none expected done"); end
        if (fc4 !== 16'd1) begin bad++; $display("[TB] FAIL rst_restart_fc: got %0d expected 1", fc4); end
        if (got4.size() != 16) begin bad++; $display("[TB] FAIL rst_restart_count: got %0d expected 16", got4.size()); end
        for (int k = 0; k < 16 && k < got4.size() && k < raddr4.size(); k++) begin
            total += 2;
            if (raddr4[k] != k) begin bad++; $display("[TB] FAIL rst_raddr%0d: got %0d expected %0d", k, raddr4[k], k); end
            if (got4[k] !== mem4[k]) begin bad++; $display("[TB] FAIL rst_pix%0d: got %0h expected %0h", k, got4[k], mem4[k]); end
        end
    endtask

    task automatic test_random_full();
        int d0;
        bit ok;
        for (int i = 0; i < 64; i++) mem8[i] = 8'($urandom);
        got8.delete(); raddr8.delete(); viol8 = 0;
        d0 = done_cnt8;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            full8 = 1'($urandom_range(0, 1));
            if (done_cnt8 > d0) begin ok = 1'b1; break; end
            tick();
        end
        full8 = 1'b0;
        total += 4;
        if (!ok) begin bad++; $display("[TB] FAIL rnd_timeout: got none expected done"); end
        if (viol8 != 0) begin bad++; $display("[TB] FAIL rnd_write_full: got %0d expected 0", viol8); end
        if (raddr8.size() != 64) begin bad++; $display("[TB] FAIL rnd_reads: got %0d expected 64", raddr8.size()); end
        if (got8.size() != 64) begin bad++; $display("[TB] FAIL rnd_count: got %0d expected 64", got8.size()); end
        for (int k = 0; k < 64 && k < got8.size(); k++) begin
            total++;
            if (got8[k] !== mem8[k]) begin bad++; $display("[TB] FAIL rnd_pix%0d: got %0h expected %0h", k, got8[k], mem8[k]); end
        end
    endtask

    task automatic test_toggle_full();
        int d0;
        bit ok;
        for (int i = 0; i < 64; i++) mem8[i] = 8'($urandom);
        got8.delete(); viol8 = 0;
        d0 = done_cnt8;
        start8 = 1'b1;
        tick();
        start8 = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            full8 = 1'(cyc);
            if (done_cnt8 > d0) begin ok = 1'b1; break; end
            tick();
        end
        full8 = 1'b0;
        total += 4;
        if (!ok) begin bad++; $display("[TB] FAIL tgl_timeout: got none expected done"); end
        if (viol8 != 0) begin bad++; $display("[TB] FAIL tgl_write_full: got %0d expected 0", viol8); end
        if (got8.size() != 64) begin bad++; $display("[TB] FAIL tgl_count: got %0d expected 64", got8.size()); end
        if (fc8 !== 16'd2) begin bad++; $display("[TB] FAIL tgl_fc: got %0d expected 2", fc8); end
        for (int k = 0; k < 64 && k < got8.size(); k++) begin
            total++;
            if (got8[k] !== mem8[k]) begin bad++; $display("[TB] FAIL tgl_pix%0d: got %0h expected %0h", k, got8[k], mem8[k]); end
        end
    endtask

    initial begin
        reset = 1'b0;
        start2 = 1'b0; start4 = 1'b0; start8 = 1'b0;
        full2 = 1'b0; full4 = 1'b0; full8 = 1'b0;
        mem2[0] = 8'h11; mem2[1] = 8'h22; mem2[2] = 8'h33; mem2[3] = 8'h44;
        for (int i = 0; i < 16; i++) mem4[i] = 8'(i);
        for (int i = 0; i < 64; i++) mem8[i] = 8'(i);
        $display("[TB] starting img_streamer bench");
        test_reset();
        test_basic_2x2();
        test_frame_wrap();
        test_backpressure();
        test_start_ignored();
        test_random_full();
        test_toggle_full();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
